// File: rtl/common.sv
// -----------------------------------------------------------------------------
// common
//   Types and constants shared by the scene generator, the object buffer and
//   the rasteriser.
//
//   obj_kind_t    primitive shape selector
//   object_t      one scene primitive: kind, screen position, depth, colour
//   OBJ_BUF_SIZE  default number of objects held per buffer bank
//   make_object   helper that packs the object_t fields
// -----------------------------------------------------------------------------
package common;

    localparam int OBJ_BUF_SIZE = 50;

    typedef enum logic [1:0] {
        OBJ_TRIANGLE = 2'd0,
        OBJ_RECT     = 2'd1,
        OBJ_CIRCLE   = 2'd2,
        OBJ_LINE     = 2'd3
    } obj_kind_t;

    typedef struct packed {
        obj_kind_t   kind;
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  depth;
        logic [7:0]  color;
    } object_t;

    function automatic object_t make_object(
        input obj_kind_t   kind,
        input logic [10:0] x,
        input logic [10:0] y,
        input logic [7:0]  depth,
        input logic [7:0]  color
    );
        object_t obj;
        obj.kind  = kind;
        obj.x     = x;
        obj.y     = y;
        obj.depth = depth;
        obj.color = color;
        return obj;
    endfunction

endpackage

// File: rtl/object_bank_ram.sv
// -----------------------------------------------------------------------------
// object_bank_ram
//   Two banks of SIZE object_t entries, addressed as {bank, index}.
//   One synchronous write port, one asynchronous (combinational) read port.
//
//   clock     in   rising-edge clock for the write port
//   wr_en     in   write strobe
//   wr_bank   in   bank selected for the write
//   wr_index  in   entry within the write bank
//   wr_data   in   object written
//   rd_bank   in   bank selected for the read
//   rd_index  in   entry within the read bank
//   rd_data   out  object at {rd_bank, rd_index}, zero latency
// -----------------------------------------------------------------------------
module object_bank_ram
    import common::*;
#(
    parameter  int SIZE  = OBJ_BUF_SIZE,
    localparam int IDX_W = $clog2(SIZE)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_index,
    input  object_t          wr_data,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_index,
    output object_t          rd_data
);

    object_t mem [2][SIZE];

    // NOTE: storage has no reset; the counters in the parent decide which
    // entries are meaningful, so clearing the array would only cost area.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignment for clocked state so every reader
        // sees the pre-edge value regardless of process ordering.
        if (wr_en) begin
            mem[wr_bank][wr_index] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_index];

endmodule

// File: rtl/object_pingpong_buffer.sv
// -----------------------------------------------------------------------------
// object_pingpong_buffer
//   Ping-pong object store between the scene generator and the rasteriser.
//   The writer appends to the back bank while the rasteriser streams the
//   front bank once; a next_frame pulse swaps the banks in a single edge.
//
//   Optional feature macro: OBJECT_BUFFER_DROP_CNT_EN
//     when defined, adds the DROP_W parameter and the dropped port, a
//     saturating count of refused writes that clears on next_frame.
//
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   next_frame  in   one-cycle pulse: swap banks
//   wr_valid    in   writer offers wr_data
//   wr_data     in   object appended to the back bank
//   wr_ready    out  back bank has room
//   rd_ready    in   rasteriser accepts rd_data
//   rd_valid    out  front bank still has an unread object
//   rd_data     out  front bank entry at the read cursor (combinational)
//   rd_index    out  read cursor
//   rd_last     out  current read entry is the last one of the front bank
//   wr_count    out  objects in the back bank
//   rd_count    out  objects in the front bank
//   dropped     out  writes refused this frame (macro builds only)
// -----------------------------------------------------------------------------
module object_pingpong_buffer
    import common::*;
#(
    parameter  int SIZE   = OBJ_BUF_SIZE,
`ifdef OBJECT_BUFFER_DROP_CNT_EN
    parameter  int DROP_W = 8,
`endif
    localparam int CNT_W  = $clog2(SIZE + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              next_frame,
    input  logic              wr_valid,
    input  object_t           wr_data,
    output logic              wr_ready,
    input  logic              rd_ready,
    output logic              rd_valid,
    output object_t           rd_data,
    output logic [CNT_W-1:0]  rd_index,
    output logic              rd_last,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
`ifdef OBJECT_BUFFER_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] dropped
`endif
);

    localparam int               IDX_W  = $clog2(SIZE);
    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);

    logic             front_sel;
    logic [CNT_W-1:0] rd_cursor;
    logic             wr_fire;
    logic             rd_fire;
    logic [IDX_W-1:0] rd_addr;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave a value held and infer a latch.
    always_comb begin
        wr_ready = 1'b0;
        wr_fire  = 1'b0;
        rd_valid = 1'b0;
        rd_fire  = 1'b0;
        rd_last  = 1'b0;
        rd_addr  = '0;

        wr_ready = (wr_count != SIZE_C);
        wr_fire  = wr_valid && wr_ready;

        rd_valid = (rd_cursor < rd_count);
        // A swap restarts the cursor, so a read handshake in that cycle is void.
        rd_fire  = rd_valid && rd_ready && !next_frame;
        // rd_count - 1 wraps when the bank is empty, but rd_valid masks it.
        rd_last  = rd_valid && (rd_cursor == rd_count - CNT_W'(1));

        // Once the bank is exhausted the cursor equals SIZE at most; keep the
        // RAM address in range then (rd_data is meaningless without rd_valid).
        if (rd_cursor < SIZE_C) begin
            rd_addr = rd_cursor[IDX_W-1:0];
        end
    end

    assign rd_index = rd_cursor;

    // -------------------------------------------------------------------------
    // Counters and bank select
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            front_sel <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
            rd_cursor <= '0;
        end else if (next_frame) begin
            front_sel <= ~front_sel;
            // A write accepted in the swap cycle lands in the outgoing back
            // bank, which is the one becoming the front.
            rd_count  <= wr_count + CNT_W'(wr_fire);
            wr_count  <= '0;
            rd_cursor <= '0;
        end else begin
            if (wr_fire) begin
                wr_count <= wr_count + CNT_W'(1);
            end
            if (rd_fire) begin
                rd_cursor <= rd_cursor + CNT_W'(1);
            end
        end
    end

`ifdef OBJECT_BUFFER_DROP_CNT_EN
    // -------------------------------------------------------------------------
    // Refused-write counter, saturating, cleared by the frame swap
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dropped <= '0;
        end else if (next_frame) begin
            dropped <= '0;
        end else if (wr_valid && !wr_ready && (dropped != {DROP_W{1'b1}})) begin
            dropped <= dropped + DROP_W'(1);
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Storage: writes go to the back bank, reads come from the front bank
    // -------------------------------------------------------------------------
    object_bank_ram #(
        .SIZE (SIZE)
    ) u_ram (
        .clock    (clock),
        .wr_en    (wr_fire),
        .wr_bank  (~front_sel),
        .wr_index (wr_count[IDX_W-1:0]),
        .wr_data  (wr_data),
        .rd_bank  (front_sel),
        .rd_index (rd_addr),
        .rd_data  (rd_data)
    );

endmodule
